param_fifo: RTL

Single-clock synchronous FIFO with a registered read port. It is the parametrised successor to the team's basic buffer, used between memory-read engines and compute pipelines. It adds an exact full/empty/count (count is LOG2_DEPTH+1 bits wide), a configurable almost-full threshold, a synchronous flush, and guarded accept rules. All state updates on the rising edge of clk only.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/param_fifo_if.sv | 28 ++
 rtl/fifo_sdp_ram.sv | 47 ++++
 rtl/param_fifo.sv | 128 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for param_fifo.
package fifo_pkg;

    // Per-cycle accept decisions for the write and read sides.
    typedef struct packed {
        logic wr_ok;
        logic rd_ok;
    } acc_t;

    // Width of the occupancy counter: one extra bit so that 0..DEPTH fits.
    function automatic int unsigned cnt_width(input int unsigned log2_depth);
        return log2_depth + 32'd1;
    endfunction

    // Occupancy at which almostfull asserts. The caller casts the result to the counter width.
    function automatic int unsigned af_thresh(input int unsigned log2_depth,
                                              input int unsigned margin);
        return (32'd1 << log2_depth) - margin;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Handshake and status bundle between a FIFO user (master) and param_fifo (slave).
interface param_fifo_if #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOG2_DEPTH = 5
);
    logic                  flush;
    logic                  we;
    logic [WIDTH-1:0]      wdata;
    logic                  re;
    logic                  rvalid;
    logic [WIDTH-1:0]      rdata;
    logic [LOG2_DEPTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  almostfull;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, we, wdata, re,
        input  rvalid, rdata, count, empty, full, almostfull, overflow, underflow
    );

    modport slave (
        input  flush, we, wdata, re,
        output rvalid, rdata, count, empty, full, almostfull, overflow, underflow
    );
endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// The output register resets to zero; the array itself is never cleared.
module fifo_sdp_ram #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOG2_DEPTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [LOG2_DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [LOG2_DEPTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    localparam int unsigned DEPTH = 32'd1 << LOG2_DEPTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read data holds unless a read is issued.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Output register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO with registered read port, exact count, almost-full and flush.
// Optional sticky overflow/underflow flags are built when PARAM_FIFO_ERRFLAG_EN is defined.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH             = 8,
    parameter int unsigned LOG2_DEPTH        = 5,
    parameter int unsigned ALMOSTFULL_MARGIN = 16
) (
    input  logic       clk,
    input  logic       reset,
    param_fifo_if.slave bus
);
    localparam int unsigned CW    = cnt_width(LOG2_DEPTH);
    localparam int unsigned DEPTH = 32'd1 << LOG2_DEPTH;

    typedef logic [CW-1:0]         cnt_t;
    typedef logic [LOG2_DEPTH-1:0] ptr_t;

    localparam cnt_t AF_THRESH = CW'(af_thresh(LOG2_DEPTH, ALMOSTFULL_MARGIN));
    localparam cnt_t FULL_CNT  = CW'(DEPTH);

    ptr_t waddr_q, waddr_d;
    ptr_t raddr_q, raddr_d;
    cnt_t count_q, count_d;
    logic rvalid_q, rvalid_d;
    acc_t acc_c;
    logic empty_c;
    logic full_c;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == FULL_CNT);

    // Accept decisions from the registered count; flush blocks both sides.
    always_comb begin
        acc_c       = '0;
        acc_c.wr_ok = bus.we & ~full_c  & ~bus.flush;
        acc_c.rd_ok = bus.re & ~empty_c & ~bus.flush;
    end

    // Pointer, count and read-valid next state.
    always_comb begin
        waddr_d  = waddr_q;
        raddr_d  = raddr_q;
        count_d  = count_q;
        rvalid_d = acc_c.rd_ok;
        if (bus.flush) begin
            waddr_d = '0;
            raddr_d = '0;
            count_d = '0;
        end else begin
            if (acc_c.wr_ok) begin
                waddr_d = waddr_q + ptr_t'(1);
            end
            if (acc_c.rd_ok) begin
                raddr_d = raddr_q + ptr_t'(1);
            end
            case ({acc_c.wr_ok, acc_c.rd_ok})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            waddr_q  <= '0;
            raddr_q  <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
        end
    end

    fifo_sdp_ram #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (acc_c.wr_ok),
        .waddr (waddr_q),
        .wdata (bus.wdata),
        .re    (acc_c.rd_ok),
        .raddr (raddr_q),
        .rdata (bus.rdata)
    );

    assign bus.rvalid     = rvalid_q;
    assign bus.count      = count_q;
    assign bus.empty      = empty_c;
    assign bus.full       = full_c;
    assign bus.almostfull = (count_q >= AF_THRESH);

`ifdef PARAM_FIFO_ERRFLAG_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky rejected-access flags; only reset clears them.
    always_comb begin
        overflow_d  = overflow_q  | (bus.we & full_c  & ~bus.flush);
        underflow_d = underflow_q | (bus.re & empty_c & ~bus.flush);
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule
